store_buffer: RTL and testbench

//  Posted-write buffer between the CPU load/store datapath and data memory.

---
 rtl/store_buffer.sv | 178 +++++++++++++++++
 tb/tb_store_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the CPU load/store path and data memory.
// Stores queue in a circular FIFO and drain one per cycle when the shared port is free.
// Loads use the port combinationally and stall while they overlap a pending store.
// Optional feature macro: STORE_BUF_FWD_EN (exact-match store-to-load forwarding).
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic              ld_valid,
  input  logic [2:0]        ld_op,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_stall,
  output logic [31:0]       ld_data,
  input  logic              drain_req,
  output logic              drained,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [2:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);

  // Access size in bytes, widened so lo+size never wraps at the top of the address space.
  function automatic logic [ADDR_W:0] op_size(input logic [2:0] op);
    case (op[1:0])
      2'b01:   op_size = (ADDR_W+1)'(1);
      2'b10:   op_size = (ADDR_W+1)'(2);
      default: op_size = (ADDR_W+1)'(4);
    endcase
  endfunction

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [2:0]        ent_op_q   [DEPTH];
  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [31:0]       ent_data_q [DEPTH];

  logic [DEPTH-1:0]            ent_hit;
  logic [DEPTH-1:0][PTR_W-1:0] ent_age;
  logic [ADDR_W:0]             l_lo, l_hi;
  logic full, pending, hit, enq, drain, load, stall;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign pending = !rst && (count_q != '0);
  assign l_lo    = {1'b0, ld_addr};
  assign l_hi    = l_lo + op_size(ld_op);

  // Per-entry age (distance from head) and load-overlap test on occupied slots.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [ADDR_W:0] s_lo, s_hi;
    assign ent_age[gi] = PTR_W'(gi) - head_q;
    assign s_lo        = {1'b0, ent_addr_q[gi]};
    assign s_hi        = s_lo + op_size(ent_op_q[gi]);
    assign ent_hit[gi] = ({1'b0, ent_age[gi]} < count_q) && (s_lo < l_hi) && (l_lo < s_hi);
  end

  // A store being reset away can never block a load.
  assign hit = !rst && (|ent_hit);

`ifdef STORE_BUF_FWD_EN
  function automatic logic [31:0] ld_extend(input logic [31:0] d, input logic [2:0] op);
    case (op)
      3'b001:  ld_extend = {{24{d[7]}}, d[7:0]};
      3'b010:  ld_extend = {{16{d[15]}}, d[15:0]};
      3'b101:  ld_extend = {24'b0, d[7:0]};
      3'b110:  ld_extend = {16'b0, d[15:0]};
      default: ld_extend = d;
    endcase
  endfunction

  logic             fwd_found, fwd_ok, fwd_use;
  logic [PTR_W-1:0] fwd_idx, fwd_age;
  logic [31:0]      fwd_data;

  // Select the youngest overlapping entry (largest age).
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    fwd_age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_hit[i] && (!fwd_found || ent_age[i] > fwd_age)) begin
        fwd_found = 1'b1;
        fwd_idx   = PTR_W'(i);
        fwd_age   = ent_age[i];
      end
    end
  end

  assign fwd_ok   = fwd_found && (ent_addr_q[fwd_idx] == ld_addr) &&
                    (op_size(ent_op_q[fwd_idx]) == op_size(ld_op));
  assign fwd_data = ld_extend(ent_data_q[fwd_idx], ld_op);
`endif

  // Port arbitration: forced drain, then clean load, then hit-drain, then idle drain.
  always_comb begin
    drain = 1'b0;
    load  = 1'b0;
    stall = 1'b0;
`ifdef STORE_BUF_FWD_EN
    fwd_use = 1'b0;
`endif
    if (pending && (full || drain_req)) begin
      drain = 1'b1;
      stall = ld_valid;
    end else if (ld_valid && !hit) begin
      load = 1'b1;
    end else if (ld_valid && hit) begin
      drain = 1'b1;
`ifdef STORE_BUF_FWD_EN
      if (fwd_ok) fwd_use = 1'b1;
      else        stall   = 1'b1;
`else
      stall = 1'b1;
`endif
    end else if (!ld_valid && pending) begin
      drain = 1'b1;
    end
  end

  // Memory port and CPU-facing outputs.
  always_comb begin
    st_ready  = !full;
    drained   = (count_q == '0);
    ld_stall  = stall;
    mem_en    = drain || load;
    mem_wr_en = drain;
    mem_op    = drain ? ent_op_q[head_q]   : ld_op;
    mem_addr  = drain ? ent_addr_q[head_q] : ld_addr;
    mem_wdata = drain ? ent_data_q[head_q] : 32'b0;
`ifdef STORE_BUF_FWD_EN
    ld_data   = fwd_use ? fwd_data : mem_rdata;
`else
    ld_data   = mem_rdata;
`endif
  end

  // Pointer and occupancy next state; enqueue is blocked when full even if draining.
  always_comb begin
    enq     = st_valid && !full && !rst;
    head_d  = head_q + PTR_W'(drain);
    tail_d  = tail_q + PTR_W'(enq);
    count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);
  end

  // Pointer/count registers; reset discards every pending store.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage written at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_op_q[tail_q]   <= st_op;
      ent_addr_q[tail_q] <= st_addr;
      ent_data_q[tail_q] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus random traffic for store_buffer, checked
// against a queue-based model of the pending stores and a byte-array memory.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, st_valid, ld_valid, drain_req;
  logic [2:0]  st_op, ld_op;
  logic [31:0] st_addr, st_data, ld_addr, mem_rdata;
  logic        st_ready, ld_stall, drained, mem_en, mem_wr_en;
  logic [2:0]  mem_op;
  logic [31:0] ld_data, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data), .ld_valid(ld_valid), .ld_op(ld_op),
    .ld_addr(ld_addr), .ld_stall(ld_stall), .ld_data(ld_data), .drain_req(drain_req),
    .drained(drained), .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mem     [256];   // memory seen by the DUT
  logic [7:0]  ref_mem [256];   // memory as the model expects it
  ent_t        pend[$];         // pending stores, oldest first
  logic [2:0]  st_ops [3] = '{3'b000, 3'b001, 3'b010};
  logic [2:0]  ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};

  // values observed in the most recent step, for directed checks
  logic        obs_st_ready, obs_drained, obs_wr, obs_stall;
  logic [31:0] obs_addr, obs_ld_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] op);
    if (op[1:0] == 2'b01) return 1;
    if (op[1:0] == 2'b10) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] op);
    case (op)
      3'b001:  return {{24{d[7]}}, d[7:0]};
      3'b010:  return {{16{d[15]}}, d[15:0]};
      3'b101:  return {24'b0, d[7:0]};
      3'b110:  return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] rd(input bit use_ref, input logic [31:0] a, input logic [2:0] op);
    logic [31:0] raw;
    logic [7:0]  idx;
    for (int k = 0; k < 4; k++) begin
      idx = a[7:0] + 8'(k);
      raw[8*k +: 8] = use_ref ? ref_mem[idx] : mem[idx];
    end
    return ext(raw, op);
  endfunction

  task automatic wr(input bit use_ref, input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
    logic [7:0] idx;
    for (int k = 0; k < sz(op); k++) begin
      idx = a[7:0] + 8'(k);
      if (use_ref) ref_mem[idx] = d[8*k +: 8];
      else         mem[idx]     = d[8*k +: 8];
    end
  endtask

  // Byte ranges [a, a+size) overlap, no wrap at the top of the address space.
  function automatic bit ovl(input logic [31:0] a, input logic [2:0] ao,
                             input logic [31:0] b, input logic [2:0] bo);
    longint alo, ahi, blo, bhi;
    alo = longint'(a); ahi = alo + sz(ao);
    blo = longint'(b); bhi = blo + sz(bo);
    return (alo < bhi) && (blo < ahi);
  endfunction

  // One clock cycle: drive inputs, predict, compare, clock, update model and memory.
  task automatic step(input bit r, input bit sv, input logic [2:0] so, input logic [31:0] sa,
                      input logic [31:0] sd, input bit lv, input logic [2:0] lo,
                      input logic [31:0] la, input bit dr);
    bit e_drain, e_load, e_stall, hit, fwd, full, dut_wr;
    ent_t y;
    logic [2:0]  w_op;
    logic [31:0] w_a, w_d;
    rst = r; st_valid = sv; st_op = so; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_op = lo; ld_addr = la; drain_req = dr;
    #1 mem_rdata = rd(1'b0, mem_addr, mem_op);
    #1;
    full = (pend.size() == DEPTH);
    hit = 1'b0; fwd = 1'b0; y = '0;
    if (!r) begin
      for (int i = int'(pend.size()) - 1; i >= 0; i--) begin
        if (!hit && ovl(pend[i].addr, pend[i].op, la, lo)) begin
          hit = 1'b1;
          y = pend[i];
        end
      end
    end
`ifdef STORE_BUF_FWD_EN
    fwd = hit && (y.addr == la) && (sz(y.op) == sz(lo));
`endif
    e_drain = 1'b0; e_load = 1'b0; e_stall = 1'b0;
    if (!r && pend.size() > 0 && (full || dr)) begin e_drain = 1'b1; e_stall = lv; end
    else if (lv && !hit)                       e_load = 1'b1;
    else if (lv)                               begin e_drain = 1'b1; e_stall = !fwd; end
    else if (!r && pend.size() > 0)            e_drain = 1'b1;

    chk("st_ready",  32'(st_ready),  32'(!full));
    chk("drained",   32'(drained),   32'(pend.size() == 0));
    chk("mem_en",    32'(mem_en),    32'(e_drain || e_load));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_drain));
    chk("ld_stall",  32'(ld_stall),  32'(e_stall));
    if (e_drain) begin
      chk("drain_addr",  mem_addr,      pend[0].addr);
      chk("drain_wdata", mem_wdata,     pend[0].data);
      chk("drain_op",    32'(mem_op),   32'(pend[0].op));
    end
    if (e_load) begin
      chk("load_addr", mem_addr,    la);
      chk("load_op",   32'(mem_op), 32'(lo));
      chk("load_data", ld_data,     rd(1'b1, la, lo));
    end
    if (lv && !e_stall && !e_load) chk("fwd_data", ld_data, ext(y.data, lo));

    obs_st_ready = st_ready; obs_drained = drained; obs_wr = mem_en && mem_wr_en;
    obs_stall = ld_stall; obs_addr = mem_addr; obs_ld_data = ld_data;
    dut_wr = mem_en && mem_wr_en; w_op = mem_op; w_a = mem_addr; w_d = mem_wdata;

    @(posedge clk);
    if (dut_wr) wr(1'b0, w_a, w_op, w_d);
    if (r) pend.delete();
    else begin
      if (e_drain) begin
        wr(1'b1, pend[0].addr, pend[0].op, pend[0].data);
        void'(pend.pop_front());
      end
      if (sv && !full) pend.push_back('{op: so, addr: sa, data: sd});
    end
    $display("t=%0t rst=%0b st=%0b %h@%h ld=%0b %0d@%h drq=%0b drain=%0b load=%0b stall=%0b pend=%0d",
             $time, r, sv, sd, sa, lv, lo, la, dr, e_drain, e_load, e_stall, pend.size());
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b0);
  endtask

  task automatic flush();
    for (int i = 0; i < DEPTH + 2; i++) idle();
  endtask

  initial begin
    logic [31:0] a0, a1, a2;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst = 1'b1; st_valid = 1'b0; ld_valid = 1'b0; drain_req = 1'b0;
    st_op = '0; ld_op = '0; st_addr = '0; st_data = '0; ld_addr = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    step(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b0);

    // 1: single word store drains on the next idle cycle
    step(1'b0, 1'b1, 3'b000, 32'h10, 32'h11223344, 1'b0, 3'b000, 32'h0, 1'b0);
    idle();
    chk("t1_wr", 32'(obs_wr), 32'd1);
    chk("t1_addr", obs_addr, 32'h10);
    idle();
    chk("t1_drained", 32'(obs_drained), 32'd1);

    // 2: fill with a non-overlapping load held, then forced drain
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 3'b000, 32'h40 + 32'(4*i), $urandom, 1'b1, 3'b000, 32'h80, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b000, 32'h80, 1'b0);
    chk("t2_full", 32'(obs_st_ready), 32'd0);
    chk("t2_stall", 32'(obs_stall), 32'd1);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b000, 32'h80, 1'b0);
    chk("t2_ready", 32'(obs_st_ready), 32'd1);
    chk("t2_nostall", 32'(obs_stall), 32'd0);
    flush();

    // 3: half load overlapping a pending byte store stalls until drained
    step(1'b0, 1'b1, 3'b001, 32'h21, 32'h80, 1'b0, 3'b000, 32'h0, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b010, 32'h20, 1'b0);
    chk("t3_stall", 32'(obs_stall), 32'd1);
    for (int i = 0; i < 4 && obs_stall; i++)
      step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b010, 32'h20, 1'b0);
    chk("t3_done", 32'(obs_stall), 32'd0);
    chk("t3_data", {8'b0, obs_ld_data[31:8]}, 32'h00FFFF80);
    flush();

    // 4: exact-match half load (forwarded when the feature is built)
    step(1'b0, 1'b1, 3'b010, 32'h30, 32'h8001, 1'b0, 3'b000, 32'h0, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b010, 32'h30, 1'b0);
`ifdef STORE_BUF_FWD_EN
    chk("t4_stall", 32'(obs_stall), 32'd0);
    chk("t4_data", obs_ld_data, 32'hFFFF8001);
`else
    chk("t4_stall", 32'(obs_stall), 32'd1);
`endif
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b110, 32'h30, 1'b0);
    for (int i = 0; i < 4 && obs_stall; i++)
      step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b110, 32'h30, 1'b0);
    chk("t4_zext", obs_ld_data, 32'h00008001);
    flush();

    // 5: three pending, drain_req with a load held -> FIFO-order writes, load stalled
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 3'b000, 32'h50 + 32'(4*i), $urandom, 1'b1, 3'b000, 32'h90, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b000, 32'h90, 1'b1); a0 = obs_addr;
    chk("t5_stall0", 32'(obs_stall), 32'd1);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b000, 32'h90, 1'b1); a1 = obs_addr;
    chk("t5_stall1", 32'(obs_stall), 32'd1);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b000, 32'h90, 1'b1); a2 = obs_addr;
    chk("t5_stall2", 32'(obs_stall), 32'd1);
    chk("t5_order0", a0, 32'h50);
    chk("t5_order1", a1, 32'h54);
    chk("t5_order2", a2, 32'h58);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b000, 32'h90, 1'b1);
    chk("t5_drained", 32'(obs_drained), 32'd1);
    chk("t5_load", 32'(obs_stall), 32'd0);

    // 6: reset with pending stores discards them, no write on the reset edge
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b1, 3'b000, 32'h60 + 32'(4*i), $urandom, 1'b1, 3'b000, 32'h90, 1'b0);
    step(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0, 1'b0);
    chk("t6_nowr", 32'(obs_wr), 32'd0);
    idle();
    chk("t6_drained", 32'(obs_drained), 32'd1);

    // top of address space: no wrap-around aliasing
    step(1'b0, 1'b1, 3'b000, 32'hFFFFFFFE, 32'hA5A5A5A5, 1'b1, 3'b000, 32'h80, 1'b0);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b001, 32'h0, 1'b0);
    chk("top_noalias", 32'(obs_stall), 32'd0);
    step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 3'b101, 32'hFFFFFFFF, 1'b0);
    chk("top_hit", 32'(obs_stall), 32'd1);
    flush();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      bit r, sv, lv, dr;
      r  = ($urandom_range(0, 59) == 0);
      sv = ($urandom_range(0, 1) == 1);
      lv = ($urandom_range(0, 4) < 3);
      dr = ($urandom_range(0, 9) == 0);
      step(r, sv, st_ops[$urandom_range(0, 2)], 32'($urandom_range(0, 48)), $urandom,
           lv, ld_ops[$urandom_range(0, 4)], 32'($urandom_range(0, 48)), dr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
